// File: rtl/ram_tp_bitmask_ctrl_if.sv
// Request/response channels and RAM pin bundle for the two-port bitmask RAM controller.
interface ram_tp_bitmask_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  init_done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  ram_cen;
  logic                  ram_wen;
  logic [DATA_WIDTH-1:0] ram_bwen;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
           ram_cen, ram_wen, ram_bwen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_req_valid, rd_req_addr,
           rd_rsp_ready, ram_rdata
  );

  modport slave (
    input  init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
           ram_cen, ram_wen, ram_bwen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
    output wr_valid, wr_addr, wr_data, wr_mask, rd_req_valid, rd_req_addr,
           rd_rsp_ready, ram_rdata
  );
endinterface

// File: rtl/ram_tp_bitmask_ctrl.sv
// Controller for a two-port bitmask RAM: post-reset clear sweep, unbuffered writes,
// and reads with a 2-entry response buffer absorbing the 1-cycle RAM read latency.
module ram_tp_bitmask_ctrl #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   DEPTH      = 16,
  parameter bit                   INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  ram_tp_bitmask_ctrl_if.master bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_last;
  logic                  init_wen;
  logic                  init_done_q;

  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic                  buf_head;
  logic [DATA_WIDTH-1:0] buf_mem [2];

  logic                  run;
  logic [1:0]            occupancy;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_valid;
  logic                  buf_pop;
  logic                  buf_push;

  // The sweep write is issued from registers, so the last entry commits on the
  // same edge that moves the FSM into RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      init_cnt    <= '0;
      init_last   <= 1'b0;
      init_wen    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (INIT_EN) begin
            state <= INIT;
          end else begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        INIT: begin
          if (!init_last) begin
            init_wen  <= 1'b1;
            init_cnt  <= init_cnt + 1'b1;
            init_last <= (init_cnt == ADDR_WIDTH'(DEPTH - 1));
          end else begin
            init_wen    <= 1'b0;
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == INIT && !init_last) init_addr <= init_cnt;
  end

  assign run       = (state == RUN);
  assign occupancy = buf_cnt + {1'b0, inflight};
  assign wr_fire   = run && bus.wr_valid;
  assign rd_fire   = bus.rd_req_valid && bus.rd_req_ready;

  assign bus.init_done    = init_done_q;
  assign bus.wr_ready     = run;
  assign bus.rd_req_ready = run && (occupancy < 2'd2);

  assign bus.ram_wen   = init_wen || wr_fire;
  assign bus.ram_waddr = init_wen ? init_addr  : (wr_fire ? bus.wr_addr : '0);
  assign bus.ram_wdata = init_wen ? INIT_VALUE : (wr_fire ? bus.wr_data : '0);
  assign bus.ram_bwen  = init_wen ? '1         : (wr_fire ? bus.wr_mask : '0);
  assign bus.ram_ren   = rd_fire;
  assign bus.ram_raddr = rd_fire ? bus.rd_req_addr : '0;
  assign bus.ram_cen   = bus.ram_wen || bus.ram_ren;

  // Response stage: buffer head first, else bypass the in-flight RAM word.
  assign rsp_valid        = (buf_cnt != 2'd0) || inflight;
  assign bus.rd_rsp_valid = rsp_valid;
  assign bus.rd_rsp_data  = (buf_cnt != 2'd0) ? buf_mem[buf_head] :
                            (inflight ? bus.ram_rdata : '0);
  assign buf_pop  = rsp_valid && bus.rd_rsp_ready && (buf_cnt != 2'd0);
  assign buf_push = inflight && ((buf_cnt != 2'd0) || !bus.rd_rsp_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf_head <= 1'b0;
    end else begin
      inflight <= rd_fire;
      buf_cnt  <= buf_cnt + {1'b0, buf_push} - {1'b0, buf_pop};
      buf_head <= buf_head ^ buf_pop;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_push) buf_mem[buf_head ^ buf_cnt[0]] <= bus.ram_rdata;
  end
endmodule

// File: tb/tb_ram_tp_bitmask_ctrl.sv
// Randomized self-checking bench for ram_tp_bitmask_ctrl with a behavioural RAM and reference model.
module tb_ram_tp_bitmask_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ram_tp_bitmask_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_tp_bitmask_ctrl #(.DATA_WIDTH(DW), .DEPTH(N), .INIT_EN(1'b1), .INIT_VALUE('0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural two-port RAM: registered read data, held when not reading.
  logic [DW-1:0] ram_mem [N];
  initial begin
    for (int i = 0; i < N; i++) ram_mem[i] = $urandom;
    bus.ram_rdata = $urandom;
  end
  always @(posedge clock) begin
    if (bus.ram_cen && bus.ram_ren) bus.ram_rdata <= ram_mem[bus.ram_raddr];
    if (bus.ram_cen && bus.ram_wen)
      ram_mem[bus.ram_waddr] <= (bus.ram_wdata & bus.ram_bwen) | (ram_mem[bus.ram_waddr] & ~bus.ram_bwen);
  end

  // Reference model: architectural memory and queue of outstanding responses.
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] exp_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_req_valid = 0; bus.rd_req_addr = '0; bus.rd_rsp_ready = 0;
  endtask

  // One RUN cycle: drive, compare against the model, then advance the model.
  task automatic drive_cycle(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [DW-1:0] wm, input bit rv, input logic [AW-1:0] ra,
                             input bit rr);
    bit exp_ready;
    @(negedge clock);
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_mask = wm;
    bus.rd_req_valid = rv; bus.rd_req_addr = ra; bus.rd_rsp_ready = rr;
    #1;
    exp_ready = (exp_q.size() < 2);
    checks++;
    if (bus.rd_req_ready !== exp_ready) begin
      errors++; $display("FAIL rd_req_ready: got %b expected %b", bus.rd_req_ready, exp_ready);
    end
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready: got %b expected 1", bus.wr_ready);
    end
    checks++;
    if (bus.rd_rsp_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL rd_rsp_valid: got %b expected %b", bus.rd_rsp_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if (bus.rd_rsp_data !== exp_q[0]) begin
        errors++; $display("FAIL rd_rsp_data: got %h expected %h", bus.rd_rsp_data, exp_q[0]);
      end
    end
    checks++;
    if (bus.ram_ren !== (rv && exp_ready) || bus.ram_wen !== wv || bus.ram_cen !== (wv || (rv && exp_ready))) begin
      errors++; $display("FAIL ram_enables: got cen=%b wen=%b ren=%b expected cen=%b wen=%b ren=%b",
                         bus.ram_cen, bus.ram_wen, bus.ram_ren, wv || (rv && exp_ready), wv, rv && exp_ready);
    end
    if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
    if (rv && exp_ready) exp_q.push_back(ref_mem[ra]);
    if (wv) ref_mem[wa] = (wd & wm) | (ref_mem[wa] & ~wm);
  endtask

  // Checks the clear sweep that follows a reset release on a falling edge.
  task automatic check_sweep();
    for (int k = 1; k <= 18; k++) begin
      @(posedge clock); #1;
      if (k == 1 || k == 18) begin
        checks++;
        if (bus.ram_cen !== 1'b0 || bus.init_done !== (k == 18)) begin
          errors++; $display("FAIL sweep_edge%0d: got cen=%b init_done=%b expected cen=0 init_done=%b",
                             k, bus.ram_cen, bus.init_done, k == 18);
        end
      end else begin
        checks++;
        if (bus.ram_cen !== 1'b1 || bus.ram_wen !== 1'b1 || bus.ram_waddr !== AW'(k - 2) ||
            bus.ram_bwen !== '1 || bus.ram_wdata !== '0 || bus.ram_ren !== 1'b0 ||
            bus.wr_ready !== 1'b0 || bus.rd_req_ready !== 1'b0 || bus.init_done !== 1'b0) begin
          errors++; $display("FAIL sweep_write%0d: got cen=%b wen=%b addr=%0d bwen=%h wdata=%h rdy=%b%b expected addr=%0d",
                             k, bus.ram_cen, bus.ram_wen, bus.ram_waddr, bus.ram_bwen, bus.ram_wdata,
                             bus.wr_ready, bus.rd_req_ready, k - 2);
        end
      end
    end
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.init_done !== 0 || bus.wr_ready !== 0 || bus.rd_req_ready !== 0 || bus.rd_rsp_valid !== 0 ||
        bus.ram_cen !== 0 || bus.ram_wen !== 0 || bus.ram_ren !== 0 || bus.ram_bwen !== '0 ||
        bus.ram_waddr !== '0 || bus.ram_wdata !== '0 || bus.ram_raddr !== '0 || bus.rd_rsp_data !== '0) begin
      errors++; $display("FAIL reset_outputs: got done=%b rdy=%b%b vld=%b cen=%b data=%h expected all zero",
                         bus.init_done, bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, bus.ram_cen, bus.rd_rsp_data);
    end
    @(negedge clock);
    reset_n = 1;
    check_sweep();
  endtask

  task automatic test_back_to_back();
    int rsp_seen = 0;
    bit ready_dropped = 0;
    for (int i = 0; i <= N; i++) begin
      drive_cycle(0, '0, '0, '0, i < N, AW'(i), 1);
      if (i < N && bus.rd_req_ready !== 1'b1) ready_dropped = 1;
      if (i > 0) begin
        checks++;
        if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== '0) begin
          errors++; $display("FAIL b2b_rsp%0d: got vld=%b data=%h expected vld=1 data=0", i - 1, bus.rd_rsp_valid, bus.rd_rsp_data);
        end else rsp_seen++;
      end
    end
    checks++;
    if (ready_dropped || rsp_seen != N) begin
      errors++; $display("FAIL b2b_throughput: got %0d responses ready_dropped=%b expected %0d and 0", rsp_seen, ready_dropped, N);
    end
    drive_cycle(0, '0, '0, '0, 0, '0, 1);
  endtask

  task automatic test_mask_bypass();
    drive_cycle(1, 4'd3, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, '0, 1);
    checks++;
    if (bus.ram_waddr !== 4'd3 || bus.ram_wdata !== 32'hA5A5A5A5 || bus.ram_bwen !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL write_bus: got addr=%0d data=%h mask=%h expected 3 a5a5a5a5 ffffffff",
                         bus.ram_waddr, bus.ram_wdata, bus.ram_bwen);
    end
    drive_cycle(1, 4'd3, 32'h00000000, 32'h0000FFFF, 0, '0, 1);
    drive_cycle(0, '0, '0, '0, 1, 4'd3, 1);
    drive_cycle(0, '0, '0, '0, 0, '0, 1);
    checks++;
    if (bus.rd_rsp_valid !== 1'b1 || bus.rd_rsp_data !== 32'hA5A50000) begin
      errors++; $display("FAIL masked_read: got vld=%b data=%h expected vld=1 data=a5a50000", bus.rd_rsp_valid, bus.rd_rsp_data);
    end
    drive_cycle(0, '0, '0, '0, 0, '0, 1);
  endtask

  task automatic test_same_cycle_hazard();
    drive_cycle(1, 4'd5, 32'h12345678, 32'hFFFFFFFF, 1, 4'd5, 1);
    drive_cycle(0, '0, '0, '0, 1, 4'd5, 1);
    checks++;
    if (bus.rd_rsp_data !== 32'h00000000) begin
      errors++; $display("FAIL hazard_old: got %h expected 00000000", bus.rd_rsp_data);
    end
    drive_cycle(0, '0, '0, '0, 0, '0, 1);
    checks++;
    if (bus.rd_rsp_data !== 32'h12345678) begin
      errors++; $display("FAIL hazard_new: got %h expected 12345678", bus.rd_rsp_data);
    end
    drive_cycle(0, '0, '0, '0, 0, '0, 1);
  endtask

  task automatic test_stall();
    int accepted = 0;
    logic [DW-1:0] held;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, '0, '0, '0, 1, AW'(i + 3), 0);
      if (bus.ram_ren === 1'b1) accepted++;
      if (i == 1) held = bus.rd_rsp_data;
      if (i >= 2) begin
        checks++;
        if (bus.rd_rsp_data !== held || bus.rd_req_ready !== 1'b0) begin
          errors++; $display("FAIL stall_hold%0d: got data=%h ready=%b expected data=%h ready=0",
                             i, bus.rd_rsp_data, bus.rd_req_ready, held);
        end
      end
    end
    checks++;
    if (accepted != 2) begin
      errors++; $display("FAIL stall_accepted: got %0d expected 2", accepted);
    end
    for (int i = 0; i < 3; i++) drive_cycle(0, '0, '0, '0, 0, '0, 1);
    checks++;
    if (exp_q.size() != 0 || bus.rd_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got vld=%b pending=%0d expected 0", bus.rd_rsp_valid, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 1), AW'($urandom), $urandom, $urandom,
                  $urandom_range(0, 9) < 6, AW'($urandom), $urandom_range(0, 9) < 7);
    for (int i = 0; i < 4; i++) drive_cycle(0, '0, '0, '0, 0, '0, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
    end
    for (int i = 0; i <= N; i++) drive_cycle(0, '0, '0, '0, i < N, AW'(i), 1);
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, '0, '0, '0, 1, 4'd1, 0);
    drive_cycle(0, '0, '0, '0, 1, 4'd2, 0);
    drive_cycle(0, '0, '0, '0, 0, '0, 0);
    checks++;
    if (bus.rd_rsp_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b expected 1", bus.rd_rsp_valid);
    end
    bus.rd_req_valid = 1;
    bus.wr_valid = 1;
    #1 reset_n = 0;
    #1;
    checks++;
    if (bus.rd_rsp_valid !== 1'b0 || bus.ram_cen !== 1'b0 || bus.rd_rsp_data !== '0) begin
      errors++; $display("FAIL async_reset: got vld=%b cen=%b data=%h expected 0 0 0",
                         bus.rd_rsp_valid, bus.ram_cen, bus.rd_rsp_data);
    end
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    check_sweep();
    for (int i = 0; i <= 4; i++) drive_cycle(0, '0, '0, '0, i < 4, AW'(i), 1);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_mask_bypass();
    test_same_cycle_hazard();
    test_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_tp_bitmask_ctrl.md
Name: ram_tp_bitmask_ctrl

Overview:
- Initiator/controller for the two-port bitmask RAM: drives its cen/wen/bwen/waddr/wdata/ren/raddr pins and consumes its registered rdata.
- Turns valid/ready write and read-request channels into RAM cycles.
- Handles the 1-cycle RAM read latency with a 2-entry response buffer and credit-based backpressure.
- Optionally sweeps the RAM to INIT_VALUE after reset.

Parameters:
DATA_WIDTH, 32, RAM word width.
DEPTH, 16, RAM entries; must be ≥2.
ADDR_WIDTH, $clog2(DEPTH), localparam, address width.
INIT_EN, 1, 1 = clear sweep after reset; 0 = go straight to RUN.
INIT_VALUE, 0, DATA_WIDTH-bit word written to every entry during the sweep.

Ports:
clock  in  1  single clock, all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
init_done  out  1  high while in RUN.
wr_valid  in  1  write request valid.
wr_ready  out  1  write accept.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_mask  in  DATA_WIDTH  per-bit write enable (1 = update bit).
rd_req_valid  in  1  read request valid.
rd_req_ready  out  1  read request accept.
rd_req_addr  in  ADDR_WIDTH  read address.
rd_rsp_valid  out  1  read data valid.
rd_rsp_ready  in  1  read data accept.
rd_rsp_data  out  DATA_WIDTH  read data.
ram_cen  out  1  RAM chip enable.
ram_wen  out  1  RAM write enable.
ram_bwen  out  DATA_WIDTH  RAM bit write enable.
ram_waddr  out  ADDR_WIDTH  RAM write address.
ram_wdata  out  DATA_WIDTH  RAM write data.
ram_ren  out  1  RAM read enable.
ram_raddr  out  ADDR_WIDTH  RAM read address.
ram_rdata  in  DATA_WIDTH  RAM read data; valid the cycle after ram_ren, held while ram_ren=0.

Behaviour:

States IDLE (reset state), INIT, RUN.
- IDLE → INIT after one clock if INIT_EN=1; IDLE → RUN if INIT_EN=0.
- INIT → RUN after the write to address DEPTH-1.

Reset (reset_n low, immediate, asynchronous):
- State = IDLE, init counter = 0, inflight = 0, buffer empty.
- Outputs: init_done, wr_ready, rd_req_ready, rd_rsp_valid, ram_cen, ram_wen, ram_ren all 0; all ram_* buses 0.
- rd_rsp_data = 0 while the buffer is empty.

IDLE:
- All ram_* outputs 0; both ready outputs 0.

INIT:
- Each cycle: ram_cen=1, ram_wen=1, ram_bwen=all ones, ram_waddr=counter, ram_wdata=INIT_VALUE; counter increments.
- Takes DEPTH cycles; wr_ready=0, rd_req_ready=0, ram_ren=0.

RUN, write path:
- wr_ready=1 every cycle.
- On wr_valid: ram_wen=1 combinationally; ram_waddr/ram_wdata/ram_bwen = wr_addr/wr_data/wr_mask.
- Write committed at that clock edge; no buffering.

RUN, read path:
- rd_req_ready = (buffer_count + inflight) < 2. Depends only on registered state, never on rd_rsp_ready.
- On rd_req_valid & rd_req_ready: ram_ren=1, ram_raddr=rd_req_addr; inflight is set for the next cycle.

RUN, enables:
- ram_cen = ram_wen | ram_ren.
- When not writing, ram_wen=0 and the ram_* write buses are 0. Same for the read buses when not reading.

Response path:
- Buffer non-empty: rd_rsp_valid=1, data = buffer head.
- Buffer empty and inflight: bypass, rd_rsp_valid=1, data = ram_rdata (read latency 1 cycle).
- Inflight data not consumed that cycle is pushed into the buffer (push and pop in the same cycle allowed). Responses are strictly in request order.
- Sustained throughput is 1 read/cycle when rd_rsp_ready=1.
- Buffer count never exceeds 2; overflow is impossible by construction.

Hazards:
- Read and write to the same address in the same cycle: read returns pre-write data.
- A read issued one or more cycles after a write sees the merged data (wdata & mask) | (old & ~mask).

Reset mid-operation:
- Pending responses are dropped; the buffer clears.
- RAM contents are unspecified until the new sweep completes (or as-is when INIT_EN=0).

Test Plan (DATA_WIDTH=32, DEPTH=16):
1. Release reset, INIT_EN=1, INIT_VALUE=0 → 1 IDLE cycle, then 16 consecutive writes at addresses 0..15 with bwen=FFFFFFFF; init_done rises on the 18th edge after release; reads of all addresses return 0.
2. Write addr 3, data A5A5A5A5, mask FFFFFFFF; then write addr 3, data 00000000, mask 0000FFFF; read addr 3 → rd_rsp_data=A5A50000, one cycle after the request via bypass.
3. Back-to-back reads of addresses 0..15 with rd_rsp_ready=1 → one response per cycle, in order, rd_req_ready never low.
4. rd_rsp_ready=0, keep issuing reads → exactly 2 requests accepted, then rd_req_ready=0; raise rd_rsp_ready → both responses delivered in order, data held stable while stalled.
5. Same cycle: write addr 5 = 12345678, read addr 5 (old value 0) → response 00000000; next read of addr 5 → 12345678.
6. Assert reset_n low with 2 responses buffered → rd_rsp_valid=0 and ram_cen=0 immediately; after release the sweep restarts from address 0.
